// File: rtl/maze_pixel_gen.sv
// Tile-based maze renderer: maps VGA pixel coordinates to 16x16 maze tiles, overlays the player and
// a blinking exit, and delays the syncs so they stay aligned with the two-stage colour path.
module maze_pixel_gen #(
    parameter int TILE_SHIFT   = 4,
    parameter int BLINK_FRAMES = 30,
    parameter int ADDR_W       = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pix_valid,
    input  logic [9:0]        i_col,
    input  logic [9:0]        i_row,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic [5:0]        i_player_tcol,
    input  logic [4:0]        i_player_trow,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [1:0]        i_rom_data,
    output logic [3:0]        o_red,
    output logic [3:0]        o_green,
    output logic [3:0]        o_blue,
    output logic              o_hsync,
    output logic              o_vsync
);

    localparam logic [1:0] CODE_WALL = 2'b01;
    localparam logic [1:0] CODE_EXIT = 2'b10;

    logic        vld_p1_q, hs_p1_q, vs_p1_q;
    logic [5:0]  tcol_p1_q;
    logic [4:0]  trow_p1_q;
    logic [11:0] rgb_p2_q, rgb_d;
    logic        hs_p2_q, vs_p2_q;

    logic        vs_last_q;
    logic [5:0]  plr_col_q;
    logic [4:0]  plr_row_q;
    logic        plr_vld_q;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        blink_q, blink_d;
    logic        frame_evt, is_player;
    logic        unused_ok;

    function automatic logic [11:0] pick_rgb(input logic vld, input logic player,
                                             input logic [1:0] code, input logic blink);
        if (!vld)                   return 12'h000;
        else if (player)            return 12'hF00;
        else if (code == CODE_WALL) return 12'h44F;
        else if (code == CODE_EXIT) return blink ? 12'h0F0 : 12'h000;
        else                        return 12'hCCC;
    endfunction

    assign o_rom_addr = {i_row[TILE_SHIFT +: 5], i_col[TILE_SHIFT +: 6]};
    assign unused_ok  = ^{i_row[9], i_row[TILE_SHIFT-1:0], i_col[TILE_SHIFT-1:0]};

    // vs_last_q resets low so a vsync held low through reset release is not taken as an edge
    assign frame_evt = vs_last_q & ~i_vsync;
    // plr_vld_q keeps the overlay off until a frame event has latched a real position
    assign is_player = plr_vld_q && (tcol_p1_q == plr_col_q) && (trow_p1_q == plr_row_q);

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (frame_evt) begin
            if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = 8'd0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        rgb_d = pick_rgb(vld_p1_q, is_player, i_rom_data, blink_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1_q    <= 1'b0;
            hs_p1_q     <= 1'b1;
            vs_p1_q     <= 1'b1;
            rgb_p2_q    <= 12'h000;
            hs_p2_q     <= 1'b1;
            vs_p2_q     <= 1'b1;
            vs_last_q   <= 1'b0;
            plr_col_q   <= 6'd0;
            plr_row_q   <= 5'd0;
            plr_vld_q   <= 1'b0;
            frame_cnt_q <= 8'd0;
            blink_q     <= 1'b0;
        end else begin
            // stage 1: capture pixel valid and syncs while the ROM is read
            vld_p1_q    <= i_pix_valid;
            hs_p1_q     <= i_hsync;
            vs_p1_q     <= i_vsync;
            // stage 2: colour decision lands on the output pins with the delayed syncs
            rgb_p2_q    <= rgb_d;
            hs_p2_q     <= hs_p1_q;
            vs_p2_q     <= vs_p1_q;
            vs_last_q   <= i_vsync;
            frame_cnt_q <= frame_cnt_d;
            blink_q     <= blink_d;
            if (frame_evt) begin
                plr_col_q <= i_player_tcol;
                plr_row_q <= i_player_trow;
                plr_vld_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tcol_p1_q <= i_col[TILE_SHIFT +: 6];
        trow_p1_q <= i_row[TILE_SHIFT +: 5];
    end

    assign o_red   = rgb_p2_q[11:8];
    assign o_green = rgb_p2_q[7:4];
    assign o_blue  = rgb_p2_q[3:0];
    assign o_hsync = hs_p2_q;
    assign o_vsync = vs_p2_q;

endmodule

// File: tb/tb_maze_pixel_gen.sv
// Directed bench for maze_pixel_gen with a small synchronous maze ROM model (BLINK_FRAMES = 2).
module tb_maze_pixel_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_pix_valid;
    logic [9:0]  i_col, i_row;
    logic        i_hsync, i_vsync;
    logic [5:0]  i_player_tcol;
    logic [4:0]  i_player_trow;
    logic [10:0] o_rom_addr;
    logic [1:0]  rom_data;
    logic [3:0]  o_red, o_green, o_blue;
    logic        o_hsync, o_vsync;
    logic [11:0] rgb;

    int checks = 0;
    int errors = 0;

    logic [1:0] mem [0:2047];

    always #5 clk = ~clk;

    maze_pixel_gen #(.TILE_SHIFT(4), .BLINK_FRAMES(2), .ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .i_pix_valid(i_pix_valid), .i_col(i_col), .i_row(i_row),
        .i_hsync(i_hsync), .i_vsync(i_vsync), .i_player_tcol(i_player_tcol),
        .i_player_trow(i_player_trow), .o_rom_addr(o_rom_addr), .i_rom_data(rom_data),
        .o_red(o_red), .o_green(o_green), .o_blue(o_blue), .o_hsync(o_hsync), .o_vsync(o_vsync)
    );

    always @(posedge clk) rom_data <= mem[o_rom_addr];
    assign rgb = {o_red, o_green, o_blue};

    typedef struct {
        logic        v;
        logic [9:0]  col;
        logic [9:0]  row;
        logic [10:0] addr;
        logic [11:0] rgb;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input string nm, input int col, input int row, input logic [11:0] exp);
        i_pix_valid = 1'b1;
        i_col = 10'(col);
        i_row = 10'(row);
        tick;
        tick;
        chk(nm, 32'(rgb), 32'(exp));
    endtask

    task automatic frame_edge(input logic [5:0] tc, input logic [4:0] tr);
        i_vsync = 1'b1;
        tick;
        tick;
        i_vsync = 1'b0;
        i_player_tcol = tc;
        i_player_trow = tr;
        tick;
        tick;
        tick;
    endtask

    task automatic sync_pulse(input bit is_v);
        logic prev = 1'b1;
        logic cur;
        logic in_v;
        int lows = 0, first = -1, bad = 0;
        i_pix_valid = 1'b0;
        for (int k = 0; k < 110; k++) begin
            in_v = (k >= 4 && k < 100) ? 1'b0 : 1'b1;
            if (is_v) i_vsync = in_v; else i_hsync = in_v;
            tick;
            cur = is_v ? o_vsync : o_hsync;
            if (cur !== prev) bad++;
            if (cur === 1'b0) begin
                lows++;
                if (first < 0) first = k;
            end
            prev = in_v;
        end
        chk(is_v ? "vsync_align" : "hsync_align", 32'(bad), 32'd0);
        chk(is_v ? "vsync_low_len" : "hsync_low_len", 32'(lows), 32'd96);
        chk(is_v ? "vsync_start" : "hsync_start", 32'(first), 32'd5);
    endtask

    logic [11:0] blink_exp [6];

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 2'b00;
        mem[0]   = 2'b01;
        mem[1]   = 2'b10;
        mem[49]  = 2'b01;
        mem[69]  = 2'b01;
        mem[131] = 2'b01;
        mem[260] = 2'b11;

        vecs[0] = '{1'b1, 10'd83,  10'd18,  11'd69,   12'h44F};
        vecs[1] = '{1'b1, 10'd64,  10'd64,  11'd260,  12'hCCC};
        vecs[2] = '{1'b1, 10'd16,  10'd0,   11'd1,    12'h000};
        vecs[3] = '{1'b0, 10'd799, 10'd520, 11'd49,   12'h000};
        vecs[4] = '{1'b0, 10'd640, 10'd480, 11'd1960, 12'h000};
        vecs[5] = '{1'b1, 10'd48,  10'd32,  11'd131,  12'h44F};

        blink_exp[0] = 12'h000;
        blink_exp[1] = 12'h0F0;
        blink_exp[2] = 12'h0F0;
        blink_exp[3] = 12'h000;
        blink_exp[4] = 12'h000;
        blink_exp[5] = 12'h0F0;

        rst = 1'b0;
        i_pix_valid = 1'b1;
        i_col = 10'd0;
        i_row = 10'd0;
        i_hsync = 1'b1;
        i_vsync = 1'b1;
        i_player_tcol = 6'd39;
        i_player_trow = 5'd29;

        // reset state, then the first pixel appears exactly two clocks after its sample
        #22;
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_hsync", 32'(o_hsync), 32'd1);
        chk("rst_vsync", 32'(o_vsync), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick;
        chk("lat1_rgb", 32'(rgb), 32'h0);
        tick;
        chk("lat2_rgb", 32'(rgb), 32'h44F);

        // sweep along row 5 across tile col 0 (floor) and tile col 1 (exit, blink off)
        mem[0] = 2'b00;
        i_row = 10'd5;
        for (int c = 0; c < 34; c++) begin
            if (c < 32) i_col = 10'(c);
            #1;
            if (c < 32) chk("sweep_addr", 32'(o_rom_addr), (c < 16) ? 32'd0 : 32'd1);
            if (c >= 2) chk("sweep_rgb", 32'(rgb), (c - 2 < 16) ? 32'hCCC : 32'h000);
            tick;
        end

        for (int i = 0; i < 6; i++) begin
            i_pix_valid = vecs[i].v;
            i_col = vecs[i].col;
            i_row = vecs[i].row;
            #1;
            chk("vec_addr", 32'(o_rom_addr), 32'(vecs[i].addr));
            tick;
            tick;
            chk("vec_rgb", 32'(rgb), 32'(vecs[i].rgb));
        end

        sync_pulse(1'b0);
        sync_pulse(1'b1);

        // player moved mid-frame stays hidden until the next frame event
        i_player_tcol = 6'd3;
        i_player_trow = 5'd2;
        pix("plr_before_edge", 50, 40, 12'h44F);
        frame_edge(6'd3, 5'd2);
        pix("plr_tl", 48, 32, 12'hF00);
        pix("plr_br", 63, 47, 12'hF00);
        pix("plr_right", 64, 32, 12'hCCC);
        pix("plr_left", 47, 47, 12'hCCC);
        pix("exit_blink_on", 16, 0, 12'h0F0);

        // player change on the same cycle as the vsync fall is taken
        i_pix_valid = 1'b0;
        frame_edge(6'd4, 5'd2);
        pix("plr_same_cycle", 64, 32, 12'hF00);
        pix("plr_old_tile", 48, 32, 12'h44F);

        // asynchronous reset mid-line
        pix("pre_rst_floor", 64, 48, 12'hCCC);
        i_hsync = 1'b0;
        tick;
        tick;
        chk("pre_rst_hsync", 32'(o_hsync), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_rgb", 32'(rgb), 32'h0);
        chk("async_rst_hsync", 32'(o_hsync), 32'd1);
        chk("async_rst_vsync", 32'(o_vsync), 32'd1);
        i_hsync = 1'b1;
        i_vsync = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick;
        tick;
        pix("post_rst_no_plr", 64, 32, 12'hCCC);
        pix("post_rst_exit", 16, 0, 12'h000);

        // blink with BLINK_FRAMES=2: toggles after edges 2, 4, 6
        for (int e = 0; e < 6; e++) begin
            frame_edge(6'd4, 5'd2);
            chk("blink_edge", 32'(rgb), 32'(blink_exp[e]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
